// File: rtl/ctle_adapt_pkg.sv
// ============================================================================
// Module : ctle_adapt_pkg
// Brief  : Shared types and helpers for the CTLE sign-sign adaptation block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctle_adapt_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2
  } state_t;

  // Direction of the most recent real code update
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  // Increment that sticks at lim instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adapt_settle_timer.sv
// ============================================================================
// Module : adapt_settle_timer
// Brief  : Counts SETTLE_CYC clocks after a load pulse; done marks the last.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adapt_settle_timer #(
  parameter int SETTLE_CYC = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic done
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Down-counter: load starts a fresh window, run walks it to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_LOAD;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = run && (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/ctle_adapt_ctrl.sv
// ============================================================================
// Module : ctle_adapt_ctrl
// Brief  : Sign-sign CTLE code adaptation with settle window and dither lock.
//          Optional statistics outputs (upd_cnt, sat_hit) are built when the
//          macro CTLE_ADAPT_STATS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctle_adapt_ctrl
  import ctle_adapt_pkg::*;
#(
  parameter int CODE_W     = 5,
  parameter int CODE_INIT  = 16,
  parameter int ACC_W      = 8,
  parameter int THRESH     = 64,
  parameter int SETTLE_CYC = 32,
  parameter int LOCK_N     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              dval,
  input  logic              dk,
  input  logic              ek,
  output logic [CODE_W-1:0] code,
  output logic              code_upd,
  output logic              locked,
  output logic              busy
`ifdef CTLE_ADAPT_STATS_EN
  ,
  output logic [15:0]       upd_cnt,
  output logic              sat_hit
`endif
);

  localparam int REV_W = $clog2(LOCK_N + 1);
  localparam logic [CODE_W-1:0]       CODE_TOP = CODE_W'((1 << CODE_W) - 1);
  localparam logic [CODE_W-1:0]       CODE_RST = CODE_W'(CODE_INIT);
  localparam logic signed [ACC_W-1:0] THR_P    = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_N    = -THR_P;
  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic [REV_W-1:0]        REV_LOCK = REV_W'(LOCK_N);

  state_t                  state;
  dir_t                    last_dir;
  logic signed [ACC_W-1:0] acc;
  logic                    d_prev;
  logic                    d_vld;
  logic [REV_W-1:0]        rev_cnt;

  logic signed [ACC_W-1:0] acc_nxt;
  logic                    corr;
  logic                    req_up;
  logic                    req_dn;
  logic                    sat_req;
  logic                    step;
  dir_t                    step_dir;
  logic [REV_W-1:0]        rev_nxt;
  logic                    settle_load;
  logic                    settle_done;

  // Correlation of the error sign with the previous decision
  assign acc_nxt  = (ek == d_prev) ? acc + ACC_ONE : acc - ACC_ONE;
  assign corr     = (state == ACCUM) && dval && d_vld;
  assign req_up   = corr && (acc_nxt >= THR_P);
  assign req_dn   = corr && (acc_nxt <= THR_N);
  assign sat_req  = (req_up && (code == CODE_TOP)) || (req_dn && (code == '0));
  assign step     = (req_up || req_dn) && !sat_req;
  assign step_dir = req_up ? DIR_UP : DIR_DN;

  // A reversal only counts against a previously recorded direction
  always_comb begin
    rev_nxt = '0;
    if ((last_dir != DIR_NONE) && (step_dir != last_dir)) begin
      rev_nxt = REV_W'(sat_inc(32'(rev_cnt), 32'(LOCK_N)));
    end
  end

  assign settle_load = en && (start || step);
  assign busy        = (state != IDLE);

  adapt_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (settle_load),
    .run  (state == SETTLE),
    .done (settle_done)
  );

  // Main controller: en low beats start, start beats normal sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code     <= CODE_RST;
      code_upd <= 1'b0;
      locked   <= 1'b0;
      acc      <= '0;
      rev_cnt  <= '0;
      last_dir <= DIR_NONE;
      d_prev   <= 1'b0;
      d_vld    <= 1'b0;
    end else if (!en) begin
      state    <= IDLE;
      code_upd <= 1'b0;
      locked   <= 1'b0;
      acc      <= '0;
      rev_cnt  <= '0;
      last_dir <= DIR_NONE;
      d_vld    <= 1'b0;
    end else if (start) begin
      state    <= SETTLE;
      code     <= CODE_RST;
      code_upd <= 1'b0;
      locked   <= 1'b0;
      acc      <= '0;
      rev_cnt  <= '0;
      last_dir <= DIR_NONE;
      d_vld    <= 1'b0;
    end else begin
      code_upd <= 1'b0;
      case (state)
        IDLE: ;
        SETTLE: begin
          d_vld <= 1'b0;
          if (settle_done) state <= ACCUM;
        end
        ACCUM: begin
          if (dval) begin
            d_prev <= dk;
            d_vld  <= 1'b1;
            if (d_vld) begin
              if (step) begin
                code     <= (step_dir == DIR_UP) ? code + 1'b1 : code - 1'b1;
                code_upd <= 1'b1;
                acc      <= '0;
                state    <= SETTLE;
                last_dir <= step_dir;
                rev_cnt  <= rev_nxt;
                locked   <= (rev_nxt == REV_LOCK);
              end else if (sat_req) begin
                acc     <= '0;
                rev_cnt <= '0;
                locked  <= 1'b0;
              end else begin
                acc <= acc_nxt;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CTLE_ADAPT_STATS_EN
  // Update counter and sticky saturation flag, both cleared on (re)start
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt <= '0;
      sat_hit <= 1'b0;
    end else if (en && start) begin
      upd_cnt <= '0;
      sat_hit <= 1'b0;
    end else if (en) begin
      if (step) upd_cnt <= 16'(sat_inc(32'(upd_cnt), 32'hFFFF));
      if (sat_req) sat_hit <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctle_adapt_ctrl.sv
// ============================================================================
// Module : tb_ctle_adapt_ctrl
// Brief  : Directed self-checking bench for ctle_adapt_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctle_adapt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, start, en2, start2, dval, dk, ek;
  logic [4:0] code, code2;
  logic code_upd, code_upd2, locked, locked2, busy, busy2;
`ifdef CTLE_ADAPT_STATS_EN
  logic [15:0] upd_cnt, upd_cnt2;
  logic sat_hit, sat_hit2;
`endif

  int n_eval = 0;
  int n_fail = 0;
  int pulses = 0;
  int pulses2 = 0;
  int p_snap;

  ctle_adapt_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .dval(dval), .dk(dk), .ek(ek),
    .code(code), .code_upd(code_upd), .locked(locked), .busy(busy)
`ifdef CTLE_ADAPT_STATS_EN
    , .upd_cnt(upd_cnt), .sat_hit(sat_hit)
`endif
  );

  ctle_adapt_ctrl #(.CODE_INIT(31)) u_sat (
    .clk(clk), .rst(rst), .en(en2), .start(start2), .dval(dval), .dk(dk), .ek(ek),
    .code(code2), .code_upd(code_upd2), .locked(locked2), .busy(busy2)
`ifdef CTLE_ADAPT_STATS_EN
    , .upd_cnt(upd_cnt2), .sat_hit(sat_hit2)
`endif
  );

  // Count cycles spent with each update strobe high
  always @(negedge clk) begin
    if (code_upd === 1'b1) pulses++;
    if (code_upd2 === 1'b1) pulses2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n valid samples with dk=1; ek=1 correlates (+1), ek=0 anti-correlates (-1)
  task automatic samples(input bit e, input int n);
    for (int i = 0; i < n; i++) begin
      dval = 1'b1; dk = 1'b1; ek = e;
      tick();
    end
    dval = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; en2 = 1'b0; start2 = 1'b0;
    dval = 1'b0; dk = 1'b0; ek = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_code", 32'(code), 32'd16);
    check("rst_upd", 32'(code_upd), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_code_sat_inst", 32'(code2), 32'd31);

    // Start: settle window ignores samples
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_code", 32'(code), 32'd16);
    samples(1'b1, 32);
    check("settle_ignored", 32'(code), 32'd16);
    samples(1'b1, 64);
    check("pre_cross_code", 32'(code), 32'd16);
    check("pre_cross_pulses", 32'(pulses), 32'd0);
    samples(1'b1, 1);
    check("cross_code", 32'(code), 32'd17);
    check("cross_upd", 32'(code_upd), 32'd1);
    samples(1'b1, 32);
    check("single_pulse", 32'(pulses), 32'd1);
    samples(1'b1, 64);
    check("settle2_ignored", 32'(code), 32'd17);
    samples(1'b1, 1);
    check("second_up_code", 32'(code), 32'd18);

    // Alternating bursts: DN,UP,... eight reversals from last UP
    for (int i = 0; i < 8; i++) begin
      bit up;
      up = (i % 2 == 1);
      samples(!up, 32);
      samples(up, 65);
      check("lock_code", 32'(code), up ? 32'd18 : 32'd17);
      if (i == 6) check("not_locked_7", 32'(locked), 32'd0);
    end
    check("locked_8", 32'(locked), 32'd1);
    samples(1'b0, 32);
    samples(1'b1, 65);
    check("same_dir_code", 32'(code), 32'd19);
    check("same_dir_unlock", 32'(locked), 32'd0);

    // en dropped mid-ACCUM with acc=40
    samples(1'b0, 32);
    samples(1'b1, 41);
    check("acc40_code", 32'(code), 32'd19);
    p_snap = pulses;
    en = 1'b0;
    tick();
    check("en_low_busy", 32'(busy), 32'd0);
    check("en_low_code", 32'(code), 32'd19);
    check("en_low_locked", 32'(locked), 32'd0);
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_code", 32'(code), 32'd16);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_no_pulse", 32'(pulses), p_snap);

    // Reach 18, then restart during SETTLE
    samples(1'b1, 32);
    samples(1'b1, 65);
    samples(1'b1, 32);
    samples(1'b1, 65);
    check("reach18", 32'(code), 32'd18);
    samples(1'b1, 10);
    p_snap = pulses;
    start = 1'b1; dval = 1'b1; dk = 1'b1; ek = 1'b1;
    tick();
    start = 1'b0; dval = 1'b0;
    check("mid_settle_code", 32'(code), 32'd16);
    check("mid_settle_upd", 32'(code_upd), 32'd0);
    samples(1'b1, 32);
    samples(1'b1, 64);
    check("full_resettle_code", 32'(code), 32'd16);
    check("mid_settle_no_pulse", 32'(pulses), p_snap);
    samples(1'b1, 1);
    check("after_resettle_code", 32'(code), 32'd17);
`ifdef CTLE_ADAPT_STATS_EN
    check("upd_cnt", 32'(upd_cnt), 32'd1);
`endif

    // Saturation instance: CODE_INIT=31
    en = 1'b0;
    tick();
    en2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    samples(1'b1, 32);
    samples(1'b1, 65);
    check("sat_code", 32'(code2), 32'd31);
    check("sat_busy", 32'(busy2), 32'd1);
    samples(1'b1, 64);
    check("sat_code_again", 32'(code2), 32'd31);
    check("sat_no_pulse", 32'(pulses2), 32'd0);
    samples(1'b0, 63);
    check("sat_acc_cleared_pre", 32'(code2), 32'd31);
    samples(1'b0, 1);
    check("sat_acc_cleared_dn", 32'(code2), 32'd30);
    check("sat_dn_upd", 32'(code_upd2), 32'd1);
`ifdef CTLE_ADAPT_STATS_EN
    check("sat_hit", 32'(sat_hit2), 32'd1);
    check("sat_upd_cnt", 32'(upd_cnt2), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
